// File: rtl/toll_lane_scheduler.sv
// Toll plaza lane scheduler: class-pair lane assignment, per-lane service FSMs, occupancy counts.
// Optional served-vehicle statistics counters are built when TOLL_STATS_EN is defined.
module toll_lane_scheduler #(
    parameter int LANE_CAP = 7,
    parameter int T_TRUCK  = 5,
    parameter int T_CAR    = 4,
    parameter int T_BIKE   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       arr_valid,
    input  logic [1:0] arr_type,
    output logic       arr_ready,
    output logic       assign_valid,
    output logic [2:0] assign_lane,
    output logic [2:0] lane1,
    output logic [2:0] lane2,
    output logic [2:0] lane3,
    output logic [2:0] lane4,
    output logic [2:0] lane5,
    output logic [2:0] lane6,
    output logic [5:0] depart_vec,
    output logic [7:0] served_truck,
    output logic [7:0] served_car,
    output logic [7:0] served_bike
);

    typedef enum logic {
        IDLE,
        SERVE
    } lane_state_t;

    lane_state_t state [0:5];
    logic [2:0]  cnt   [0:5];
    logic [7:0]  timer [0:5];

    logic [2:0]  pair_base;
    logic [2:0]  sel;
    logic [2:0]  cnt_a;
    logic [2:0]  cnt_b;
    logic [2:0]  min_cnt;
    logic        pick_b;
    logic        accept;
    logic [5:0]  acc;
    logic [5:0]  dep;
    logic [2:0]  next_cnt [0:5];

    function automatic logic [7:0] t_of(input int unsigned lane);
        if (lane < 2)
            return 8'(T_TRUCK);
        else if (lane < 4)
            return 8'(T_CAR);
        else
            return 8'(T_BIKE);
    endfunction

    // Illegal type is steered to pair 0 only to keep array indices in range; it is never accepted.
    always_comb begin
        pair_base = (arr_type == 2'b11) ? 3'd0 : {arr_type, 1'b0};
        cnt_a     = cnt[pair_base];
        cnt_b     = cnt[pair_base + 3'd1];
        pick_b    = (cnt_a > cnt_b);
        sel       = pair_base + {2'b00, pick_b};
        min_cnt   = pick_b ? cnt_b : cnt_a;
        arr_ready = enable && (arr_type != 2'b11) && ({1'b0, min_cnt} < 4'(LANE_CAP));
        accept    = arr_valid && arr_ready;
    end

    always_comb begin
        acc = '0;
        dep = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            acc[i]      = accept && (sel == 3'(i));
            dep[i]      = enable && (state[i] == SERVE) && (timer[i] == 8'd1);
            next_cnt[i] = cnt[i] + {2'b00, acc[i]} - {2'b00, dep[i]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            assign_valid <= 1'b0;
            assign_lane  <= '0;
            depart_vec   <= '0;
            for (int unsigned i = 0; i < 6; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
                timer[i] <= '0;
            end
        end else begin
            assign_valid <= accept;
            if (accept)
                assign_lane <= sel + 3'd1;
            depart_vec <= dep;
            for (int unsigned i = 0; i < 6; i++) begin
                cnt[i] <= next_cnt[i];
                case (state[i])
                    IDLE: begin
                        if (acc[i]) begin
                            state[i] <= SERVE;
                            timer[i] <= t_of(i);
                        end
                    end
                    SERVE: begin
                        if (enable) begin
                            if (timer[i] == 8'd1) begin
                                // A same-edge arrival keeps the lane busy, so the next head starts fresh.
                                if (next_cnt[i] != 3'd0) begin
                                    timer[i] <= t_of(i);
                                end else begin
                                    state[i] <= IDLE;
                                    timer[i] <= '0;
                                end
                            end else begin
                                timer[i] <= timer[i] - 8'd1;
                            end
                        end
                    end
                    default: begin
                        state[i] <= IDLE;
                        timer[i] <= '0;
                    end
                endcase
            end
        end
    end

    assign lane1 = cnt[0];
    assign lane2 = cnt[1];
    assign lane3 = cnt[2];
    assign lane4 = cnt[3];
    assign lane5 = cnt[4];
    assign lane6 = cnt[5];

`ifdef TOLL_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            served_truck <= '0;
            served_car   <= '0;
            served_bike  <= '0;
        end else begin
            served_truck <= served_truck + {7'd0, dep[0]} + {7'd0, dep[1]};
            served_car   <= served_car   + {7'd0, dep[2]} + {7'd0, dep[3]};
            served_bike  <= served_bike  + {7'd0, dep[4]} + {7'd0, dep[5]};
        end
    end
`else
    assign served_truck = '0;
    assign served_car   = '0;
    assign served_bike  = '0;
`endif

endmodule

// File: tb/tb_toll_lane_scheduler.sv
// Bench for toll_lane_scheduler: directed scenarios plus random traffic against a
// departure-time queue model (each lane holds the scheduled release times of its vehicles).
module tb_toll_lane_scheduler;

    localparam int CAP = 7;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       arr_valid = 1'b0;
    logic [1:0] arr_type = 2'b00;
    logic       arr_ready;
    logic       assign_valid;
    logic [2:0] assign_lane;
    logic [2:0] lane1, lane2, lane3, lane4, lane5, lane6;
    logic [5:0] depart_vec;
    logic [7:0] served_truck, served_car, served_bike;

    toll_lane_scheduler #(
        .LANE_CAP(7),
        .T_TRUCK (5),
        .T_CAR   (4),
        .T_BIKE  (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .arr_valid   (arr_valid),
        .arr_type    (arr_type),
        .arr_ready   (arr_ready),
        .assign_valid(assign_valid),
        .assign_lane (assign_lane),
        .lane1       (lane1),
        .lane2       (lane2),
        .lane3       (lane3),
        .lane4       (lane4),
        .lane5       (lane5),
        .lane6       (lane6),
        .depart_vec  (depart_vec),
        .served_truck(served_truck),
        .served_car  (served_car),
        .served_bike (served_bike)
    );

    always #5 clk = ~clk;

    // q[l] holds, in enabled-edge time, the edge at which each waiting vehicle leaves.
    int         q [0:5][$];
    int         ek;
    int         n_cmp;
    int         n_bad;
    logic [2:0] exp_lane;
    logic [7:0] exp_st, exp_sc, exp_sb;

    function automatic int t_cls(input int l);
        return (l < 2) ? 5 : (l < 4) ? 4 : 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int l = 0; l < 6; l++) q[l].delete();
        exp_lane = '0;
        exp_st   = '0;
        exp_sc   = '0;
        exp_sb   = '0;
    endtask

    function automatic logic [17:0] model_lanes();
        logic [17:0] v;
        for (int l = 0; l < 6; l++) v[l*3 +: 3] = 3'(q[l].size());
        return v;
    endfunction

    task automatic step(input bit en, input bit v, input logic [1:0] ty);
        bit         r;
        bit         acc;
        int         sel;
        int         a;
        logic [5:0] dep;
        enable    = en;
        arr_valid = v;
        arr_type  = ty;
        #1;
        r   = 1'b0;
        sel = 0;
        if (en && ty != 2'b11) begin
            a   = 2 * int'(ty);
            sel = (q[a].size() > q[a+1].size()) ? a + 1 : a;
            r   = (q[sel].size() < CAP);
        end
        chk("arr_ready", {31'd0, arr_ready}, {31'd0, r});
        acc = v && r;
        @(posedge clk);
        #1;
        dep = '0;
        if (en) begin
            ek++;
            for (int l = 0; l < 6; l++) begin
                if (q[l].size() > 0 && q[l][0] == ek) begin
                    void'(q[l].pop_front());
                    dep[l] = 1'b1;
                end
            end
            if (acc) begin
                if (q[sel].size() > 0) q[sel].push_back(q[sel][$] + t_cls(sel));
                else                   q[sel].push_back(ek + t_cls(sel));
                exp_lane = 3'(sel + 1);
            end
        end
`ifdef TOLL_STATS_EN
        exp_st = exp_st + 8'(dep[0]) + 8'(dep[1]);
        exp_sc = exp_sc + 8'(dep[2]) + 8'(dep[3]);
        exp_sb = exp_sb + 8'(dep[4]) + 8'(dep[5]);
`endif
        chk("assign_valid", {31'd0, assign_valid}, {31'd0, acc});
        chk("assign_lane", {29'd0, assign_lane}, {29'd0, exp_lane});
        chk("lanes", {14'd0, lane6, lane5, lane4, lane3, lane2, lane1}, {14'd0, model_lanes()});
        chk("depart_vec", {26'd0, depart_vec}, {26'd0, dep});
        chk("served", {8'd0, served_truck, served_car, served_bike}, {8'd0, exp_st, exp_sc, exp_sb});
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        ek    = 0;
        model_clear();

        // Reset state
        #12;
        chk("rst_lanes", {14'd0, lane6, lane5, lane4, lane3, lane2, lane1}, 32'd0);
        chk("rst_outs", {23'd0, assign_valid, assign_lane, depart_vec}, 32'd0);
        chk("rst_served", {8'd0, served_truck, served_car, served_bike}, 32'd0);
        chk("rst_ready", {31'd0, arr_ready}, 32'd0);
        reset = 1'b1;

        // One truck into an idle plaza, released five enabled edges later
        step(1, 1, 2'b00);
        chk("t1_lane", {29'd0, assign_lane}, 32'd1);
        chk("t1_lane1", {29'd0, lane1}, 32'd1);
        for (int i = 0; i < 5; i++) step(1, 0, 2'b00);
        chk("t1_depart", {26'd0, depart_vec}, 32'h01);
        chk("t1_lane1_empty", {29'd0, lane1}, 32'd0);

        // Two cars back to back split across lanes 3 and 4
        step(1, 1, 2'b01);
        chk("t2_first", {29'd0, assign_lane}, 32'd3);
        step(1, 1, 2'b01);
        chk("t2_second", {29'd0, assign_lane}, 32'd4);
        for (int i = 0; i < 5; i++) step(1, 0, 2'b00);

        // Illegal type is refused
        step(1, 1, 2'b11);
        chk("t6_illegal", {31'd0, arr_ready}, 32'd0);

        // Flood trucks until both truck lanes saturate; refusals and same-edge accept/depart follow
        for (int i = 0; i < 30; i++) step(1, 1, 2'b00);
        chk("fill_full", {26'd0, lane2, lane1}, {26'd0, 3'd7, 3'd7});

        // Car with a three-cycle freeze mid-service
        step(1, 1, 2'b01);
        chk("t5_lane", {29'd0, assign_lane}, 32'd3);
        step(1, 0, 2'b00);
        for (int i = 0; i < 3; i++) step(0, 1, 2'b01);
        step(1, 0, 2'b00);
        step(1, 0, 2'b00);
        chk("t5_early", {31'd0, depart_vec[2]}, 32'd0);
        step(1, 0, 2'b00);
        chk("t5_depart", {31'd0, depart_vec[2]}, 32'd1);

        // Reset mid-service: clears immediately, nothing departs afterwards
        step(1, 1, 2'b01);
        step(1, 1, 2'b01);
        step(1, 1, 2'b01);
        #3;
        reset = 1'b0;
        #1;
        chk("mid_rst_lanes", {14'd0, lane6, lane5, lane4, lane3, lane2, lane1}, 32'd0);
        chk("mid_rst_outs", {23'd0, assign_valid, assign_lane, depart_vec}, 32'd0);
        chk("mid_rst_served", {8'd0, served_truck, served_car, served_bike}, 32'd0);
        model_clear();
        #1;
        reset = 1'b1;
        for (int i = 0; i < 8; i++) step(1, 0, 2'b00);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
